// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types, constants and helpers for the stopwatch display
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    localparam int DIGITS   = 4;
    localparam int BCD_W    = 16;
    localparam int BIN_W    = 14;
    localparam int DP_DIGIT = 2;

    // Active-low cathodes ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] w_code;
        case (nibble)
            4'd0:    w_code = SEG_0;
            4'd1:    w_code = SEG_1;
            4'd2:    w_code = SEG_2;
            4'd3:    w_code = SEG_3;
            4'd4:    w_code = SEG_4;
            4'd5:    w_code = SEG_5;
            4'd6:    w_code = SEG_6;
            4'd7:    w_code = SEG_7;
            4'd8:    w_code = SEG_8;
            4'd9:    w_code = SEG_9;
            default: w_code = SEG_BLANK;
        endcase
        return w_code;
    endfunction

    // Double-dabble correction: any digit >= 5 gets +3 before the next shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] w_res;
        w_res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                w_res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 14-bit binary to 4-digit BCD converter, one bit/cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int         c_shift_w   = BCD_W + BIN_W;
    localparam logic [3:0] c_last_iter = 4'(BIN_W - 1);

    conv_state_t            r_state;
    logic [c_shift_w-1:0]   r_shift;
    logic [3:0]             r_iter;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_done;
    logic [c_shift_w-1:0]   w_adjusted;

    assign w_adjusted = {bcd_adjust(r_shift[c_shift_w-1 -: BCD_W]), r_shift[BIN_W-1:0]};

    // r_bcd only moves in DONE, so the scan never sees a partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_iter  <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= {{BCD_W{1'b0}}, bin};
                        r_iter  <= '0;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_shift <= {w_adjusted[c_shift_w-2:0], 1'b0};
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == c_last_iter) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_shift[c_shift_w-1 -: BCD_W];
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/count_display.sv
// ============================================================================
//  Module      : count_display
//  Description : Stopwatch count to multiplexed 4-digit 7-segment display (SS.hh)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_COUNT   = 9999
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] count_in,
    input  logic             blank_lz,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [BCD_W-1:0] bcd_out,
    output logic             conv_done
);

    localparam int               c_pre_w    = $clog2(REFRESH_DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(REFRESH_DIV - 1);
    localparam logic [BIN_W-1:0] c_max      = BIN_W'(MAX_COUNT);

    logic [BIN_W-1:0]   r_last_value;
    logic               r_busy;
    logic [c_pre_w-1:0] r_pre;
    logic [1:0]         r_digit_sel;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic [BIN_W-1:0]   w_clamped;
    logic               w_conv_idle;
    logic               w_start;
    logic [BCD_W-1:0]   w_bcd;
    logic               w_done;
    logic [3:0]         w_nibble;
    logic               w_blank;

    assign w_clamped = (count_in > c_max) ? c_max : count_in;

    // The converter is back in IDLE during its done cycle, so that cycle may start again
    assign w_conv_idle = !r_busy || w_done;
    assign w_start     = w_conv_idle && (count_in != r_last_value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_value <= '0;
            r_busy       <= 1'b0;
        end else if (w_start) begin
            r_last_value <= count_in;
            r_busy       <= 1'b1;
        end else if (w_done) begin
            r_busy       <= 1'b0;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (w_clamped),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    assign w_nibble = w_bcd[{r_digit_sel, 2'b00} +: 4];
    assign w_blank  = blank_lz && (r_digit_sel == 2'd3) && (w_bcd[15:12] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre       <= '0;
            r_digit_sel <= '0;
            r_an        <= 4'b1111;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
        end else begin
            if (r_pre == c_pre_last) begin
                r_pre       <= '0;
                r_digit_sel <= r_digit_sel + 2'd1;
            end else begin
                r_pre <= r_pre + c_pre_w'(1);
            end
            r_an  <= w_blank ? 4'b1111 : ~(4'b0001 << r_digit_sel);
            r_seg <= w_blank ? SEG_BLANK : seg_encode(w_nibble);
            r_dp  <= (r_digit_sel != 2'(DP_DIGIT));
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign bcd_out   = w_bcd;
    assign conv_done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_count_display.sv
// ============================================================================
//  Module      : tb_count_display
//  Description : Directed self-checking bench for count_display
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_display;

    localparam int c_timeout = 40;

    logic        clk;
    logic        reset;
    logic [13:0] count_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd_out;
    logic        conv_done;

    int n_checks;
    int n_failures;
    int n_pulses;

    logic [6:0] slot_seg  [4];
    logic       slot_dp   [4];
    logic       slot_seen [4];
    logic       blank_seen;

    count_display #(
        .REFRESH_DIV (4),
        .MAX_COUNT   (9999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .bcd_out   (bcd_out),
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_done === 1'b1) n_pulses++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the number of rising edges until conv_done is seen, counting the capture edge as 1
    task automatic wait_done(output int edges);
        edges = c_timeout + 1;
        for (int k = 1; k <= c_timeout; k++) begin
            @(posedge clk);
            #1;
            if (conv_done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic apply_count(input logic [13:0] value, input logic [15:0] exp_bcd, input string tag);
        int edges;
        @(negedge clk);
        count_in = value;
        wait_done(edges);
        check_value({tag, "_latency"}, edges, 16);
        check_value({tag, "_bcd"}, bcd_out, exp_bcd);
        @(posedge clk);
        #1;
        check_value({tag, "_pulse_low"}, conv_done, 1'b0);
    endtask

    task automatic scan_display();
        for (int i = 0; i < 4; i++) begin
            slot_seg[i]  = 7'h00;
            slot_dp[i]   = 1'b0;
            slot_seen[i] = 1'b0;
        end
        blank_seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            case (an)
                4'b1110: begin slot_seg[0] = seg; slot_dp[0] = dp; slot_seen[0] = 1'b1; end
                4'b1101: begin slot_seg[1] = seg; slot_dp[1] = dp; slot_seen[1] = 1'b1; end
                4'b1011: begin slot_seg[2] = seg; slot_dp[2] = dp; slot_seen[2] = 1'b1; end
                4'b0111: begin slot_seg[3] = seg; slot_dp[3] = dp; slot_seen[3] = 1'b1; end
                4'b1111: blank_seen = 1'b1;
                default: check_value("an_onehot", an, 4'b1110);
            endcase
        end
    endtask

    initial begin
        int edges;
        int pulses_before;
        n_checks   = 0;
        n_failures = 0;
        n_pulses   = 0;
        reset      = 1'b1;
        count_in   = 14'd0;
        blank_lz   = 1'b0;

        repeat (3) @(negedge clk);
        check_value("rst_an", an, 4'b1111);
        check_value("rst_seg", seg, 7'b1111111);
        check_value("rst_dp", dp, 1'b1);
        check_value("rst_bcd", bcd_out, 16'h0000);
        check_value("rst_done", conv_done, 1'b0);

        reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("rel_an", an, 4'b1110);
        check_value("rel_seg", seg, 7'b1000000);
        check_value("rel_dp", dp, 1'b1);

        // 1234 -> "12.34"
        apply_count(14'd1234, 16'h1234, "c1234");
        scan_display();
        check_value("s1234_seg0", slot_seg[0], 7'b0011001);
        check_value("s1234_seg1", slot_seg[1], 7'b0110000);
        check_value("s1234_seg2", slot_seg[2], 7'b0100100);
        check_value("s1234_seg3", slot_seg[3], 7'b1111001);
        check_value("s1234_dp0", slot_dp[0], 1'b1);
        check_value("s1234_dp1", slot_dp[1], 1'b1);
        check_value("s1234_dp2", slot_dp[2], 1'b0);
        check_value("s1234_dp3", slot_dp[3], 1'b1);
        check_value("s1234_blank", blank_seen, 1'b0);

        // Clamping
        apply_count(14'd16383, 16'h9999, "c16383");
        apply_count(14'd10000, 16'h9999, "c10000");
        apply_count(14'd9999, 16'h9999, "c9999_neq");

        // Leading-zero blanking
        blank_lz = 1'b1;
        apply_count(14'd250, 16'h0250, "c0250");
        scan_display();
        check_value("blz_slot3_seen", slot_seen[3], 1'b0);
        check_value("blz_blank_seen", blank_seen, 1'b1);
        check_value("blz_seg2", slot_seg[2], 7'b0100100);
        check_value("blz_seg1", slot_seg[1], 7'b0010010);
        check_value("blz_seg0", slot_seg[0], 7'b1000000);
        blank_lz = 1'b0;
        scan_display();
        check_value("nolz_slot3_seen", slot_seen[3], 1'b1);
        check_value("nolz_seg3", slot_seg[3], 7'b1000000);
        check_value("nolz_blank_seen", blank_seen, 1'b0);

        // Change during conversion: both values convert, two pulses
        pulses_before = n_pulses;
        @(negedge clk);
        count_in = 14'd100;
        repeat (6) @(negedge clk);
        count_in = 14'd101;
        wait_done(edges);
        check_value("mid_first_found", (edges <= c_timeout), 1'b1);
        check_value("mid_first_bcd", bcd_out, 16'h0100);
        wait_done(edges);
        check_value("mid_second_latency", edges, 16);
        check_value("mid_second_bcd", bcd_out, 16'h0101);
        repeat (30) @(negedge clk);
        check_value("mid_pulses", n_pulses - pulses_before, 2);
        check_value("mid_bcd_hold", bcd_out, 16'h0101);

        // Reset during CONV iteration 7
        @(negedge clk);
        count_in = 14'd9999;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_an", an, 4'b1111);
        check_value("arst_seg", seg, 7'b1111111);
        check_value("arst_dp", dp, 1'b1);
        check_value("arst_bcd", bcd_out, 16'h0000);
        check_value("arst_done", conv_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(edges);
        check_value("post_rst_latency", edges, 16);
        check_value("post_rst_bcd", bcd_out, 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

`default_nettype wire
